// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: single-player pong game controller. Holds the game FSM,
// paddle and ball kinematics, score and lives; motion advances once per
// video frame on refresh_tick.
module pong_game_ctrl #(
  parameter int unsigned H_VIS        = 640,
  parameter int unsigned V_VIS        = 480,
  parameter int unsigned WALL_X_R     = 35,
  parameter int unsigned PAD_X_L      = 600,
  parameter int unsigned PAD_H        = 72,
  parameter int unsigned BALL_SZ      = 8,
  parameter int unsigned BALL_V       = 2,
  parameter int unsigned PAD_V        = 4,
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       btn_start,
  output logic [9:0] paddle_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [2:0] state,
  output logic       game_over
);

  // Internal coordinate width is one bit wider than the outputs so sums never wrap.
  localparam int unsigned CW  = 11;
  localparam int unsigned OW  = 10;
  localparam int unsigned SW  = 8;
  localparam int unsigned LW  = 2;
  localparam int unsigned SCW = 16;

  localparam logic [CW-1:0]  BALL_X0    = CW'((H_VIS - BALL_SZ) / 2);
  localparam logic [CW-1:0]  BALL_Y0    = CW'((V_VIS - BALL_SZ) / 2);
  localparam logic [CW-1:0]  PAD_Y0     = CW'((V_VIS - PAD_H) / 2);
  localparam logic [CW-1:0]  PAD_Y_MAX  = CW'(V_VIS - PAD_H);
  localparam logic [CW-1:0]  PAD_STEP   = CW'(PAD_V);
  localparam logic [CW-1:0]  BALL_STEP  = CW'(BALL_V);
  localparam logic [CW-1:0]  TOP_LIM    = CW'(BALL_V);
  localparam logic [CW-1:0]  BOT_LIM    = CW'(V_VIS - BALL_V);
  localparam logic [CW-1:0]  WALL_LIM   = CW'(WALL_X_R + 1);
  localparam logic [CW-1:0]  HIT_X_LO   = CW'(PAD_X_L);
  localparam logic [CW-1:0]  HIT_X_HI   = CW'(PAD_X_L + 3);
  localparam logic [CW-1:0]  MISS_X     = CW'(H_VIS - BALL_SZ);
  localparam logic [CW-1:0]  SZ         = CW'(BALL_SZ);
  localparam logic [CW-1:0]  SZ_M1      = CW'(BALL_SZ - 1);
  localparam logic [CW-1:0]  PAD_H_M1   = CW'(PAD_H - 1);
  localparam logic [SCW-1:0] SERVE_LAST = SCW'(SERVE_FRAMES - 1);
  localparam logic [LW-1:0]  LIVES0     = LW'(LIVES_INIT);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SERVE    = 3'd1,
    S_PLAY     = 3'd2,
    S_POINT    = 3'd3,
    S_GAMEOVER = 3'd4
  } state_t;

  state_t         st_q, st_nxt;
  logic [CW-1:0]  pad_q, pad_nxt, pad_mv;
  logic [CW-1:0]  bx_q, bx_nxt;
  logic [CW-1:0]  by_q, by_nxt;
  logic           dx_q, dx_nxt;   // 1 = moving right
  logic           dy_q, dy_nxt;   // 1 = moving down
  logic [SW-1:0]  score_q, score_nxt;
  logic [LW-1:0]  lives_q, lives_nxt;
  logic [SCW-1:0] cnt_q, cnt_nxt;
  logic           go_q, go_nxt;
  logic           start_d_q;
  logic           start_pulse;
  logic           hit;
  logic           miss;

  // Rising edge of the start button; a held button yields a single pulse.
  assign start_pulse = btn_start & ~start_d_q;

  // Ball overlaps the paddle's 4-px hit strip while travelling toward it.
  assign hit = dx_q
             && (bx_q + SZ_M1 >= HIT_X_LO) && (bx_q <= HIT_X_HI)
             && (by_q + SZ_M1 >= pad_q)    && (by_q <= pad_q + PAD_H_M1);

  // Ball reached the right edge without touching the paddle.
  assign miss = (bx_q >= MISS_X) && !hit;

  // Paddle position after one frame of button motion, clamped to the screen.
  always_comb begin
    pad_mv = pad_q;
    if (btn_up && !btn_dn) begin
      pad_mv = (pad_q >= PAD_STEP) ? pad_q - PAD_STEP : '0;
    end else if (btn_dn && !btn_up) begin
      pad_mv = (pad_q + PAD_STEP >= PAD_Y_MAX) ? PAD_Y_MAX : pad_q + PAD_STEP;
    end
  end

  // Next state and next datapath values; everything holds unless a rule fires.
  always_comb begin
    st_nxt    = st_q;
    pad_nxt   = pad_q;
    bx_nxt    = bx_q;
    by_nxt    = by_q;
    dx_nxt    = dx_q;
    dy_nxt    = dy_q;
    score_nxt = score_q;
    lives_nxt = lives_q;
    cnt_nxt   = cnt_q;

    case (st_q)
      S_IDLE: begin
        if (start_pulse) begin
          st_nxt    = S_SERVE;
          score_nxt = '0;
          lives_nxt = LIVES0;
          cnt_nxt   = '0;
          bx_nxt    = BALL_X0;
          by_nxt    = BALL_Y0;
        end
      end

      S_SERVE: begin
        bx_nxt = BALL_X0;
        by_nxt = BALL_Y0;
        if (refresh_tick) begin
          pad_nxt = pad_mv;
          if (cnt_q == SERVE_LAST) begin
            st_nxt = S_PLAY;
            dx_nxt = 1'b1;
            dy_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt_q + SCW'(1);
          end
        end
      end

      S_PLAY: begin
        if (refresh_tick) begin
          pad_nxt = pad_mv;
          if (miss) begin
            lives_nxt = (lives_q == '0) ? '0 : lives_q - LW'(1);
            st_nxt    = S_POINT;
          end else begin
            bx_nxt = dx_q ? bx_q + BALL_STEP : bx_q - BALL_STEP;
            by_nxt = dy_q ? by_q + BALL_STEP : by_q - BALL_STEP;
            if (by_q <= TOP_LIM) begin
              dy_nxt = 1'b1;
            end else if (by_q + SZ >= BOT_LIM) begin
              dy_nxt = 1'b0;
            end
            if (hit) begin
              dx_nxt = 1'b0;
            end else if (bx_q <= WALL_LIM) begin
              dx_nxt = 1'b1;
            end
            if (hit && (score_q != '1)) begin
              score_nxt = score_q + SW'(1);
            end
          end
        end
      end

      S_POINT: begin
        if (lives_q == '0) begin
          st_nxt = S_GAMEOVER;
        end else begin
          st_nxt  = S_SERVE;
          cnt_nxt = '0;
          bx_nxt  = BALL_X0;
          by_nxt  = BALL_Y0;
        end
      end

      S_GAMEOVER: begin
        if (start_pulse) begin
          st_nxt = S_IDLE;
        end
      end

      default: begin
        st_nxt = S_IDLE;
      end
    endcase

    go_nxt = (st_nxt == S_GAMEOVER);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q <= S_IDLE;
    end else begin
      st_q <= st_nxt;
    end
  end

  // Datapath, output flags and start-button delay register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pad_q     <= PAD_Y0;
      bx_q      <= BALL_X0;
      by_q      <= BALL_Y0;
      dx_q      <= 1'b1;
      dy_q      <= 1'b1;
      score_q   <= '0;
      lives_q   <= LIVES0;
      cnt_q     <= '0;
      go_q      <= 1'b0;
      start_d_q <= 1'b0;
    end else begin
      pad_q     <= pad_nxt;
      bx_q      <= bx_nxt;
      by_q      <= by_nxt;
      dx_q      <= dx_nxt;
      dy_q      <= dy_nxt;
      score_q   <= score_nxt;
      lives_q   <= lives_nxt;
      cnt_q     <= cnt_nxt;
      go_q      <= go_nxt;
      start_d_q <= btn_start;
    end
  end

  // Outputs are slices of the registers above.
  assign paddle_y  = pad_q[OW-1:0];
  assign ball_x    = bx_q[OW-1:0];
  assign ball_y    = by_q[OW-1:0];
  assign score     = score_q;
  assign lives     = lives_q;
  assign state     = st_q;
  assign game_over = go_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: randomized bench for pong_game_ctrl against a
// frame-level game model kept in plain integers.
module tb_pong_game_ctrl;

  localparam int HV    = 640;
  localparam int VV    = 480;
  localparam int WALL  = 35;
  localparam int PXL   = 600;
  localparam int PH    = 72;
  localparam int BSZ   = 8;
  localparam int BV    = 2;
  localparam int PV    = 4;
  localparam int LIVES = 3;
  localparam int SERVE = 60;
  localparam int CX    = 316;
  localparam int CY    = 236;
  localparam int PAD0  = 204;
  localparam int PMAX  = VV - PH;

  localparam int ST_IDLE  = 0;
  localparam int ST_SERVE = 1;
  localparam int ST_PLAY  = 2;
  localparam int ST_POINT = 3;
  localparam int ST_OVER  = 4;

  logic       clk;
  logic       reset;
  logic       refresh_tick;
  logic       btn_up;
  logic       btn_dn;
  logic       btn_start;
  logic [9:0] paddle_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [7:0] score;
  logic [1:0] lives;
  logic [2:0] state;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  // Model of the game as seen from the screen.
  int m_st, m_pad, m_bx, m_by, m_vx, m_vy, m_score, m_lives, m_ticks;
  bit m_prev_start;
  bit last_tk;

  logic [43:0] rst_vec;

  pong_game_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .refresh_tick (refresh_tick),
    .btn_up       (btn_up),
    .btn_dn       (btn_dn),
    .btn_start    (btn_start),
    .paddle_y     (paddle_y),
    .ball_x       (ball_x),
    .ball_y       (ball_y),
    .score        (score),
    .lives        (lives),
    .state        (state),
    .game_over    (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [43:0] dut_vec();
    return {paddle_y, ball_x, ball_y, score, lives, state, game_over};
  endfunction

  function automatic logic [43:0] mdl_vec();
    return {10'(m_pad), 10'(m_bx), 10'(m_by), 8'(m_score), 2'(m_lives), 3'(m_st), 1'(m_st == ST_OVER)};
  endfunction

  function automatic bit overlap(input int a0, input int a1, input int b0, input int b1);
    return (a1 >= b0) && (a0 <= b1);
  endfunction

  function automatic int paddle_after(input int p, input bit up, input bit dn);
    if (up && !dn) return (p - PV < 0) ? 0 : p - PV;
    if (dn && !up) return (p + PV > PMAX) ? PMAX : p + PV;
    return p;
  endfunction

  function automatic bit rand_tick();
    bit t;
    t = !last_tk && ($urandom_range(0, 3) != 0);
    last_tk = t;
    return t;
  endfunction

  task automatic model_reset();
    m_st = ST_IDLE; m_pad = PAD0; m_bx = CX; m_by = CY;
    m_vx = BV; m_vy = BV; m_score = 0; m_lives = LIVES; m_ticks = 0;
    m_prev_start = 1'b0;
  endtask

  // One clock of game rules, applied to the model.
  task automatic model_clk(input bit tk, input bit up, input bit dn, input bit st);
    bit sp, hit;
    int nvx, nvy;
    sp = st && !m_prev_start;
    m_prev_start = st;
    case (m_st)
      ST_IDLE: if (sp) begin
        m_st = ST_SERVE; m_score = 0; m_lives = LIVES; m_ticks = 0; m_bx = CX; m_by = CY;
      end
      ST_SERVE: if (tk) begin
        m_pad = paddle_after(m_pad, up, dn);
        m_ticks++;
        if (m_ticks == SERVE) begin m_st = ST_PLAY; m_vx = BV; m_vy = BV; end
      end
      ST_PLAY: if (tk) begin
        hit = (m_vx > 0) && overlap(m_bx, m_bx + BSZ - 1, PXL, PXL + 3)
                         && overlap(m_by, m_by + BSZ - 1, m_pad, m_pad + PH - 1);
        m_pad = paddle_after(m_pad, up, dn);
        if (!hit && m_bx >= HV - BSZ) begin
          m_lives = (m_lives > 0) ? m_lives - 1 : 0;
          m_st = ST_POINT;
        end else begin
          nvx = m_vx; nvy = m_vy;
          if (m_by <= BV) nvy = BV;
          else if (m_by + BSZ >= VV - BV) nvy = -BV;
          if (m_bx <= WALL + 1) nvx = BV;
          if (hit) begin
            nvx = -BV;
            m_score = (m_score >= 255) ? 255 : m_score + 1;
          end
          m_bx += m_vx; m_by += m_vy;
          m_vx = nvx; m_vy = nvy;
        end
      end
      ST_POINT: begin
        if (m_lives == 0) m_st = ST_OVER;
        else begin m_st = ST_SERVE; m_ticks = 0; m_bx = CX; m_by = CY; end
      end
      ST_OVER: if (sp) m_st = ST_IDLE;
      default: m_st = ST_IDLE;
    endcase
  endtask

  // Drive inputs at the falling edge, update the model, sample after the rising edge.
  task automatic step(input bit tk, input bit up, input bit dn, input bit st);
    @(negedge clk);
    refresh_tick = tk; btn_up = up; btn_dn = dn; btn_start = st;
    model_clk(tk, up, dn, st);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; refresh_tick = 1'b0; btn_up = 1'b0; btn_dn = 1'b0; btn_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== rst_vec) begin
      errors++; $display("FAIL reset_values got=%h exp=%h", dut_vec(), rst_vec);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step(i[0], 1'b1, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL idle_frozen got=%h exp=%h", dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_start_serve();
    logic [2:0] exp_st;
    bit up, dn;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (state !== 3'd1 || dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL start_to_serve got=%h exp=%h", dut_vec(), mdl_vec());
    end
    for (int i = 1; i <= SERVE; i++) begin
      up = 1'($urandom_range(0, 1)); dn = 1'($urandom_range(0, 1));
      step(1'b1, up, dn, 1'b1);
      exp_st = (i < SERVE) ? 3'd1 : 3'd2;
      checks++;
      if (state !== exp_st || ball_x !== 10'd316 || ball_y !== 10'd236 || dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL serve_tick%0d state=%0d exp=%0d ball=(%0d,%0d) got=%h model=%h",
                 i, state, exp_st, ball_x, ball_y, dut_vec(), mdl_vec());
      end
      step(1'b0, up, dn, 1'b0);
    end
    last_tk = 1'b0;
  endtask

  task automatic test_play_game();
    int cyc;
    bit tk, up, dn, anti;
    logic [1:0] lv_q[$];
    cyc = 0;
    while (m_st != ST_OVER && cyc < 40000) begin
      tk = rand_tick();
      if (m_score < 2) begin
        up = (m_pad + PH / 2) > (m_by + BSZ / 2 + 2);
        dn = (m_pad + PH / 2) < (m_by + BSZ / 2 - 2);
      end else begin
        anti = ($urandom_range(0, 9) != 0);
        if (anti) begin
          dn = (m_by + BSZ / 2) < VV / 2;
          up = !dn;
        end else begin
          up = 1'($urandom_range(0, 1)); dn = 1'($urandom_range(0, 1));
        end
      end
      step(tk, up, dn, 1'b0);
      cyc++;
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL play_cyc%0d got=%h exp=%h", cyc, dut_vec(), mdl_vec());
      end
      if (state === 3'd3) lv_q.push_back(lives);
    end
    checks++;
    if (m_st != ST_OVER) begin
      errors++; $display("FAIL game_timeout model_state=%0d dut_state=%0d", m_st, state);
    end
    checks++;
    if (lv_q.size() != 3 || lv_q[0] !== 2'd2 || lv_q[1] !== 2'd1 || lv_q[2] !== 2'd0) begin
      errors++; $display("FAIL lives_sequence points=%0d got=%p exp=2,1,0", lv_q.size(), lv_q);
    end
    checks++;
    if (state !== 3'd4 || game_over !== 1'b1 || lives !== 2'd0) begin
      errors++; $display("FAIL gameover_flags state=%0d go=%0b lives=%0d exp 4/1/0", state, game_over, lives);
    end
  endtask

  task automatic test_gameover_hold();
    logic [7:0] sc;
    logic [9:0] pd;
    sc = 8'(m_score); pd = 10'(m_pad);
    for (int i = 0; i < 6; i++) begin
      step(i[0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      checks++;
      if (score !== sc || paddle_y !== pd || game_over !== 1'b1 || dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL gameover_frozen score=%0d exp=%0d pad=%0d exp=%0d", score, sc, paddle_y, pd);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (state !== 3'd0 || game_over !== 1'b0 || dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL gameover_to_idle state=%0d go=%0b exp 0/0", state, game_over);
    end
    for (int i = 0; i < 6; i++) begin
      step(i[0], 1'b0, 1'b0, 1'b1);
      checks++;
      if (state !== 3'd0 || dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL held_start_chained state=%0d exp=0", state);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (state !== 3'd1 || lives !== 2'd3 || score !== 8'd0 || dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL restart state=%0d lives=%0d score=%0d exp 1/3/0", state, lives, score);
    end
  endtask

  task automatic test_paddle_clamp();
    int n_tk[4];
    bit up_v[4], dn_v[4];
    logic [9:0] exp_pad[4];
    n_tk    = '{110, 110, 10, 5};
    up_v    = '{1'b0, 1'b1, 1'b0, 1'b1};
    dn_v    = '{1'b1, 1'b0, 1'b1, 1'b1};
    exp_pad = '{10'd408, 10'd0, 10'd40, 10'd40};
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < n_tk[ph]; i++) begin
        step(1'b1, up_v[ph], dn_v[ph], 1'b0);
        checks++;
        if (dut_vec() !== mdl_vec()) begin
          errors++; $display("FAIL clamp_ph%0d_t%0d got=%h exp=%h", ph, i, dut_vec(), mdl_vec());
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
      end
      checks++;
      if (paddle_y !== exp_pad[ph]) begin
        errors++; $display("FAIL clamp_end_ph%0d pad=%0d exp=%0d", ph, paddle_y, exp_pad[ph]);
      end
    end
    last_tk = 1'b0;
  endtask

  task automatic test_reset_mid_play();
    int cyc;
    cyc = 0;
    while (m_st != ST_PLAY && cyc < 2000) begin
      step(rand_tick(), 1'b0, 1'b0, 1'b0);
      cyc++;
    end
    checks++;
    if (state !== 3'd2) begin
      errors++; $display("FAIL reach_play state=%0d exp=2", state);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    refresh_tick = 1'b0; btn_up = 1'b0; btn_dn = 1'b0; btn_start = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== rst_vec) begin
      errors++; $display("FAIL async_reset got=%h exp=%h", dut_vec(), rst_vec);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== rst_vec) begin
      errors++; $display("FAIL reset_held got=%h exp=%h", dut_vec(), rst_vec);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (state !== 3'd0 || dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL post_reset_idle got=%h exp=%h", dut_vec(), mdl_vec());
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (state !== 3'd1 || dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL post_reset_start got=%h exp=%h", dut_vec(), mdl_vec());
    end
  endtask

  initial begin
    rst_vec = {10'd204, 10'd316, 10'd236, 8'd0, 2'd3, 3'd0, 1'b0};
    last_tk = 1'b0;
    model_reset();
    test_reset();
    test_start_serve();
    test_play_game();
    test_gameover_hold();
    test_paddle_clamp();
    test_reset_mid_play();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
